// File: rtl/mst_arb_pkg.sv
// Shared definitions for the two-port master FIFO arbiter: word field
// positions and the arbitration state encoding.
package mst_arb_pkg;

  localparam int SOP_BIT = 17;
  localparam int EOP_BIT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mst_arb_outreg.sv
// Single-entry holding register in front of the master FIFO write port.
// A new word may load while the held word drains in the same cycle.
module mst_arb_outreg #(
  parameter int DW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  input  logic          mst_full,
  output logic          stall,
  output logic [DW-1:0] mst_din,
  output logic          mst_wr_en
);

  logic          out_v_q, out_v_d;
  logic [DW-1:0] out_data_q, out_data_d;

  always_comb begin
    out_v_d    = out_v_q;
    out_data_d = out_data_q;
    if (in_vld) begin
      out_v_d    = 1'b1;
      out_data_d = in_data;
    end else if (out_v_q && !mst_full) begin
      out_v_d = 1'b0;
    end
  end

  // Data is cleared on reset so mst_din reads zero afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v_q    <= 1'b0;
      out_data_q <= '0;
    end else begin
      out_v_q    <= out_v_d;
      out_data_q <= out_data_d;
    end
  end

  assign stall     = out_v_q & mst_full;
  assign mst_wr_en = out_v_q & ~mst_full;
  assign mst_din   = out_data_q;

endmodule

// File: rtl/mst_arbiter.sv
// Packet-granular two-port arbiter for the bus-master command FIFO with a
// per-grant stall watchdog. Optional counters: define MST_ARB_STATS_EN.
module mst_arbiter
  import mst_arb_pkg::*;
#(
  parameter int DW      = 18,
  parameter int TIMEOUT = 1024,
  parameter int TMO_W   = 11
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          req0,
  output logic          gnt0,
  input  logic [DW-1:0] din0,
  input  logic          wr_en0,
  output logic          full0,
  input  logic          req1,
  output logic          gnt1,
  input  logic [DW-1:0] din1,
  input  logic          wr_en1,
  output logic          full1,
  output logic [DW-1:0] mst_din,
  output logic          mst_wr_en,
  input  logic          mst_full,
  output logic          tmo_err,
  output logic          tmo_port
`ifdef MST_ARB_STATS_EN
  ,
  output logic [15:0]   pkt_cnt0,
  output logic [15:0]   pkt_cnt1,
  output logic [7:0]    tmo_cnt
`endif
);

  arb_state_e       state_q, state_d;
  logic             rr_last_q, rr_last_d;
  logic [TMO_W-1:0] wd_q, wd_d;
  logic             tmo_err_q, tmo_err_d;
  logic             tmo_port_q, tmo_port_d;

  logic             stall;
  logic             acc0, acc1, acc, acc_eop;
  logic [DW-1:0]    acc_data;

  assign gnt0  = (state_q == G0);
  assign gnt1  = (state_q == G1);
  assign full0 = ~gnt0 | stall;
  assign full1 = ~gnt1 | stall;

  assign acc0     = wr_en0 & ~full0;
  assign acc1     = wr_en1 & ~full1;
  assign acc      = acc0 | acc1;
  assign acc_data = acc1 ? din1 : din0;
  assign acc_eop  = acc & acc_data[EOP_BIT];

  // The watchdog only counts cycles the granted port could have written.
  always_comb begin
    state_d    = state_q;
    rr_last_d  = rr_last_q;
    wd_d       = wd_q;
    tmo_err_d  = 1'b0;
    tmo_port_d = tmo_port_q;
    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (req0 && (!req1 || rr_last_q)) begin
          state_d = G0;
        end else if (req1) begin
          state_d = G1;
        end
      end
      G0, G1: begin
        if (acc) begin
          wd_d = '0;
          if (acc_eop) begin
            state_d   = IDLE;
            rr_last_d = (state_q == G1);
          end
        end else if (!stall) begin
          if (wd_q == TMO_W'(TIMEOUT - 1)) begin
            state_d    = IDLE;
            rr_last_d  = (state_q == G1);
            tmo_err_d  = 1'b1;
            tmo_port_d = (state_q == G1);
            wd_d       = '0;
          end else begin
            wd_d = wd_q + TMO_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      rr_last_q  <= 1'b1;
      wd_q       <= '0;
      tmo_err_q  <= 1'b0;
      tmo_port_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_last_q  <= rr_last_d;
      wd_q       <= wd_d;
      tmo_err_q  <= tmo_err_d;
      tmo_port_q <= tmo_port_d;
    end
  end

  assign tmo_err  = tmo_err_q;
  assign tmo_port = tmo_port_q;

  mst_arb_outreg #(.DW(DW)) u_outreg (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .in_vld    (acc),
    .in_data   (acc_data),
    .mst_full  (mst_full),
    .stall     (stall),
    .mst_din   (mst_din),
    .mst_wr_en (mst_wr_en)
  );

`ifdef MST_ARB_STATS_EN
  logic [15:0] pkt_cnt0_q, pkt_cnt0_d;
  logic [15:0] pkt_cnt1_q, pkt_cnt1_d;
  logic [7:0]  tmo_cnt_q, tmo_cnt_d;

  // Packet counters wrap; the timeout counter saturates.
  always_comb begin
    pkt_cnt0_d = pkt_cnt0_q;
    pkt_cnt1_d = pkt_cnt1_q;
    tmo_cnt_d  = tmo_cnt_q;
    if (acc_eop && acc0) pkt_cnt0_d = pkt_cnt0_q + 16'd1;
    if (acc_eop && acc1) pkt_cnt1_d = pkt_cnt1_q + 16'd1;
    if (tmo_err_q && (tmo_cnt_q != 8'hFF)) tmo_cnt_d = tmo_cnt_q + 8'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pkt_cnt0_q <= '0;
      pkt_cnt1_q <= '0;
      tmo_cnt_q  <= '0;
    end else begin
      pkt_cnt0_q <= pkt_cnt0_d;
      pkt_cnt1_q <= pkt_cnt1_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign pkt_cnt0 = pkt_cnt0_q;
  assign pkt_cnt1 = pkt_cnt1_q;
  assign tmo_cnt  = tmo_cnt_q;
`endif

endmodule

// File: tb/tb_mst_arbiter.sv
// Scoreboard bench for mst_arbiter: stimulus queues expected master-FIFO
// words, an independent monitor pops and compares them on mst_wr_en.
module tb_mst_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        wr_en0 = 1'b0, wr_en1 = 1'b0;
  logic [17:0] din0 = '0, din1 = '0;
  logic        mst_full = 1'b0;
  logic        gnt0, gnt1, full0, full1, mst_wr_en, tmo_err, tmo_port;
  logic [17:0] mst_din;
`ifdef MST_ARB_STATS_EN
  logic [15:0] pkt_cnt0, pkt_cnt1;
  logic [7:0]  tmo_cnt;
`endif

  mst_arbiter #(.DW(18), .TIMEOUT(8), .TMO_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .req0      (req0),
    .gnt0      (gnt0),
    .din0      (din0),
    .wr_en0    (wr_en0),
    .full0     (full0),
    .req1      (req1),
    .gnt1      (gnt1),
    .din1      (din1),
    .wr_en1    (wr_en1),
    .full1     (full1),
    .mst_din   (mst_din),
    .mst_wr_en (mst_wr_en),
    .mst_full  (mst_full),
    .tmo_err   (tmo_err),
    .tmo_port  (tmo_port)
`ifdef MST_ARB_STATS_EN
    ,
    .pkt_cnt0  (pkt_cnt0),
    .pkt_cnt1  (pkt_cnt1),
    .tmo_cnt   (tmo_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int cyc_n = 0;
  always @(posedge sys_clk) cyc_n <= cyc_n + 1;

  typedef struct {
    logic [17:0] w;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [17:0] mkw(input bit sop, input bit eop, input logic [15:0] d);
    return {sop, eop, d};
  endfunction

  // Monitor: every word written to the master FIFO must match the queue head.
  always @(negedge sys_clk) begin
    if (!sys_rst && mst_wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: actual=%0h required=none", mst_din);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mst_din", {14'd0, mst_din}, {14'd0, mon_e.w});
        if (mon_e.lat) chk("latency_cycle", cyc_n, mon_e.cyc);
      end
    end
  end

  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic drive_word(input bit p, input logic [17:0] w, input bit lat);
    bit ok;
    ok = 1'b0;
    if (p) begin wr_en1 = 1'b1; din1 = w; end
    else   begin wr_en0 = 1'b1; din0 = w; end
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!(p ? full1 : full0)) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (ok) exp_q.push_back('{w, cyc_n + 1, lat});
    else begin
      checks++;
      errors++;
      $display("FAIL drive_timeout: actual=full required=accepted port=%0d", p);
    end
    cyc();
    if (p) wr_en1 = 1'b0;
    else   wr_en0 = 1'b0;
  endtask

  task automatic wait_gnt(input bit p);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      if (p ? gnt1 : gnt0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_gnt", {31'd0, ok}, 32'd1);
  endtask

  task automatic reset_dut();
    cyc();
    sys_rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    mst_full = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    sys_rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gnt0"}, {31'd0, gnt0}, 32'd0);
    chk({tag, "_gnt1"}, {31'd0, gnt1}, 32'd0);
    chk({tag, "_mst_wr_en"}, {31'd0, mst_wr_en}, 32'd0);
    chk({tag, "_mst_din"}, {14'd0, mst_din}, 32'd0);
    chk({tag, "_tmo_err"}, {31'd0, tmo_err}, 32'd0);
    chk({tag, "_tmo_port"}, {31'd0, tmo_port}, 32'd0);
    chk({tag, "_full0"}, {31'd0, full0}, 32'd1);
    chk({tag, "_full1"}, {31'd0, full1}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_dut();
    @(negedge sys_clk);
    chk_reset_vals("rst");

    // Port 0 alone: four-word packet.
    cyc();
    req0 = 1'b1;
    @(negedge sys_clk);
    chk("a_gnt0_pre", {31'd0, gnt0}, 32'd0);
    cyc();
    @(negedge sys_clk);
    chk("a_gnt0_rise", {31'd0, gnt0}, 32'd1);
    chk("a_full0_open", {31'd0, full0}, 32'd0);
    drive_word(0, mkw(1, 0, 16'hA000), 1);
    drive_word(0, mkw(0, 0, 16'hA001), 1);
    drive_word(0, mkw(0, 0, 16'hA002), 1);
    drive_word(0, mkw(0, 1, 16'hA003), 1);
    req0 = 1'b0;
    @(negedge sys_clk);
    chk("a_gnt0_fall", {31'd0, gnt0}, 32'd0);
    chk("a_full0_closed", {31'd0, full0}, 32'd1);

    // Both requesting from reset: 0, then 1, then 0 again.
    reset_dut();
    req0 = 1'b1;
    req1 = 1'b1;
    cyc();
    @(negedge sys_clk);
    chk("b_first_gnt0", {31'd0, gnt0}, 32'd1);
    chk("b_first_gnt1", {31'd0, gnt1}, 32'd0);
    drive_word(0, mkw(1, 0, 16'hB000), 1);
    drive_word(0, mkw(0, 1, 16'hB001), 1);
    @(negedge sys_clk);
    chk("b_idle_gap", {30'd0, gnt0, gnt1}, 32'd0);
    cyc();
    @(negedge sys_clk);
    chk("b_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    drive_word(1, mkw(1, 0, 16'hC000), 1);
    drive_word(1, mkw(0, 0, 16'hC001), 1);
    drive_word(1, mkw(0, 1, 16'hC002), 1);
    @(negedge sys_clk);
    chk("b_idle_gap2", {30'd0, gnt0, gnt1}, 32'd0);
    cyc();
    @(negedge sys_clk);
    chk("b_back_to_0", {30'd0, gnt0, gnt1}, 32'd2);
    drive_word(0, mkw(1, 1, 16'hB010), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge sys_clk);
    chk("b_single_release", {30'd0, gnt0, gnt1}, 32'd0);
    cyc();
    @(negedge sys_clk);
    chk("b_stays_idle", {30'd0, gnt0, gnt1}, 32'd0);

    // Master FIFO full for 10 cycles mid-packet.
    cyc();
    req0 = 1'b1;
    cyc();
    @(negedge sys_clk);
    chk("c_gnt0", {31'd0, gnt0}, 32'd1);
    drive_word(0, mkw(1, 0, 16'hD000), 0);
    mst_full = 1'b1;
    wr_en0 = 1'b1;
    din0 = mkw(0, 0, 16'hD001);
    for (int i = 0; i < 10; i++) begin
      @(negedge sys_clk);
      chk("c_full0", {31'd0, full0}, 32'd1);
      chk("c_no_wr", {31'd0, mst_wr_en}, 32'd0);
      chk("c_hold", {14'd0, mst_din}, {14'd0, mkw(1, 0, 16'hD000)});
      chk("c_gnt_kept", {30'd0, gnt0, tmo_err}, 32'd2);
      cyc();
    end
    mst_full = 1'b0;
    wr_en0 = 1'b0;
    drive_word(0, mkw(0, 0, 16'hD001), 1);
    drive_word(0, mkw(0, 1, 16'hD002), 1);
    req0 = 1'b0;
    @(negedge sys_clk);
    chk("c_no_tmo", {31'd0, tmo_err}, 32'd0);
    chk("c_release", {31'd0, gnt0}, 32'd0);

    // Watchdog: port 1 granted but silent, port 0 waiting.
    cyc();
    req0 = 1'b1;
    req1 = 1'b1;
    cyc();
    @(negedge sys_clk);
    chk("d_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      @(negedge sys_clk);
      chk("d_wait", {30'd0, gnt1, tmo_err}, 32'd2);
    end
    cyc();
    @(negedge sys_clk);
    chk("d_tmo_err", {31'd0, tmo_err}, 32'd1);
    chk("d_tmo_port", {31'd0, tmo_port}, 32'd1);
    chk("d_revoked", {30'd0, gnt0, gnt1}, 32'd0);
    cyc();
    @(negedge sys_clk);
    chk("d_tmo_pulse", {31'd0, tmo_err}, 32'd0);
    chk("d_pending0", {30'd0, gnt0, gnt1}, 32'd2);
    drive_word(0, mkw(1, 1, 16'hE000), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge sys_clk);
    chk("d_release", {30'd0, gnt0, gnt1}, 32'd0);

    // Reset in the middle of a port 1 packet.
    cyc();
    req1 = 1'b1;
    cyc();
    @(negedge sys_clk);
    chk("e_gnt1", {30'd0, gnt0, gnt1}, 32'd1);
    drive_word(1, mkw(1, 0, 16'hF000), 1);
    sys_rst = 1'b1;
    exp_q.delete();
    req0 = 1'b1;
    wr_en1 = 1'b1;
    din1 = mkw(0, 0, 16'hF001);
    cyc();
    sys_rst = 1'b0;
    wr_en1 = 1'b0;
    @(negedge sys_clk);
    chk_reset_vals("e_rst");
    cyc();
    @(negedge sys_clk);
    chk("e_post_rst_port0", {30'd0, gnt0, gnt1}, 32'd2);
    drive_word(0, mkw(1, 1, 16'hF100), 1);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge sys_clk);
    chk("e_release", {30'd0, gnt0, gnt1}, 32'd0);

`ifdef MST_ARB_STATS_EN
    // Three packets on port 0, then one timeout.
    reset_dut();
    for (int k = 0; k < 3; k++) begin
      req0 = 1'b1;
      wait_gnt(0);
      drive_word(0, mkw(1, 1, 16'h5000 + 16'(k)), 1);
      req0 = 1'b0;
      cyc();
    end
    req0 = 1'b1;
    wait_gnt(0);
    req0 = 1'b0;
    repeat (12) cyc();
    @(negedge sys_clk);
    chk("s_pkt_cnt0", {16'd0, pkt_cnt0}, 32'd3);
    chk("s_pkt_cnt1", {16'd0, pkt_cnt1}, 32'd0);
    chk("s_tmo_cnt", {24'd0, tmo_cnt}, 32'd1);
`endif

    repeat (3) cyc();
    @(negedge sys_clk);
    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mst_arbiter.md
Name: mst_arbiter

Overview:
- Two-port, packet-granular arbiter that shares the single bus-master command FIFO (18-bit words, consumed by the PCIe TLP engine) between the PHY1 and PHY2 receivers.
- Sits between the receiver instances and the master FIFO write port, in the clk_125 domain.
- Guarantees TLP words from different requesters never interleave.
- Provides one registered output stage and a per-grant stall watchdog.

Parameters:
- DW, 18, word width; bit 17 = SOP, bit 16 = EOP, bits 15:0 = TLP halfword.
- TIMEOUT, 1024, max cycles a grant may stay open without an accepted word.
- TMO_W, 11, watchdog counter width; must satisfy 2^TMO_W > TIMEOUT.

Ports:
- sys_clk  in  1  system clock (clk_125).
- sys_rst  in  1  synchronous, active-high reset.
- req0  in  1  port 0 (PHY1 receiver) requests a packet slot; level, held until its EOP word is accepted.
- gnt0  out  1  port 0 owns the FIFO.
- din0  in  DW  port 0 word.
- wr_en0  in  1  port 0 write strobe.
- full0  out  1  port 0 backpressure.
- req1, gnt1, din1, wr_en1, full1  as port 0, for port 1 (PHY2 receiver).
- mst_din  out  DW  word to master FIFO.
- mst_wr_en  out  1  master FIFO write.
- mst_full  in  1  master FIFO full.
- tmo_err  out  1  one-cycle pulse when the watchdog revokes a grant.
- tmo_port  out  1  port that was revoked; valid with tmo_err.

Behaviour:
- States: IDLE, G0, G1. gnt0 = (state==G0); gnt1 = (state==G1). Both are registered; they are never high together.
- IDLE, with only one req high: go to that port's grant state next cycle.
- IDLE, with both req high: grant the port with priority. rr_last holds the last served port (reset 1, so port 0 wins first). The port != rr_last wins.
- An accepted word is wr_enN & ~fullN.
- fullN = ~gntN | (out_v & mst_full). Combinational from registers plus mst_full.
- wr_enN while fullN is high is ignored. No word is stored and no error is raised.
- Output stage: one holding register (out_q, out_v).
  - mst_wr_en = out_v & ~mst_full; mst_din = out_q.
  - An accepted word loads out_q and sets out_v. This is allowed when out_v=0 or the current word drains in the same cycle.
  - out_v clears when the word drains and no new word is accepted.
  - Latency: accepted word appears on mst_din the next cycle.
  - Throughput: 1 word/cycle while mst_full=0.
- Grant release: an accepted word with bit16 (EOP) set moves the state to IDLE next cycle and sets rr_last to that port.
  - A word with SOP and EOP both set is a single-word packet. It releases after one word.
- No re-grant in the cycle following release; IDLE always lasts at least 1 cycle.
- SOP is not checked by the arbiter. It is forwarded verbatim.
- Watchdog:
  - Counter clears on grant entry and on each accepted word.
  - It increments every granted cycle in which no word is accepted and out_v & mst_full is 0. It is frozen while stalled by the FIFO.
  - When it reaches TIMEOUT: state goes to IDLE, rr_last gets the revoked port, tmo_err=1 for 1 cycle, tmo_port is set.
  - Any word already in out_q still drains. No filler words are generated.
- req dropped while granted without EOP: treated as stall; only the watchdog releases.
- Reset: state=IDLE, gnt0=gnt1=0, out_v=0, mst_wr_en=0, mst_din=0, rr_last=1, watchdog=0, tmo_err=0, tmo_port=0. A packet in flight is discarded; the downstream FIFO is reset by the same sys_rst.

Optional Feature:
- Macro: MST_ARB_STATS_EN.
- When defined, it adds the following outputs:
  - pkt_cnt0[15:0] and pkt_cnt1[15:0]: increment on each accepted EOP word of that port, wrap at 16'hFFFF to 0.
  - tmo_cnt[7:0]: increments on tmo_err, saturates at 8'hFF.
  - All three reset to 0.
- When undefined, these ports and their registers do not exist. Arbitration behaviour is identical either way.

Decomposition:
- Shared package/header (setup.v style defines): SOP_BIT=17, EOP_BIT=16, state encodings IDLE=2'd0, G0=2'd1, G1=2'd2.
- One natural sub-module: mst_arb_outreg, the single-entry holding register with the valid/full handshake. The FSM, round-robin and watchdog stay in the top.

Test Plan:
- Port 0 only: req0=1, 4 words, the last with EOP, mst_full=0.
  - gnt0 rises 1 cycle after req0.
  - mst_din shows the 4 words in order, each 1 cycle after acceptance.
  - gnt0 falls after the EOP word.
- Both req high from reset: port 0 is served first.
  - Port 1 is granted after port 0's EOP plus the 1 IDLE cycle.
  - With both still requesting, the next grant goes back to port 0.
  - No interleaving on mst_din.
- mst_full=1 for 10 cycles mid-packet:
  - full0=1 and mst_wr_en=0 throughout; out_q holds its word.
  - No word is lost or duplicated after release.
  - Watchdog does not fire even with TIMEOUT=8.
- TIMEOUT=8, grant port 1 then hold wr_en1=0:
  - tmo_err pulses with tmo_port=1 on the 8th idle granted cycle.
  - Pending port 0 is granted next.
- Assert sys_rst mid-packet: all outputs return to reset values in the following cycle, and the first post-reset grant goes to port 0.
- Stats build (MST_ARB_STATS_EN): 3 packets on port 0, then 1 timeout. Expected pkt_cnt0=3, pkt_cnt1=0, tmo_cnt=1.
